pe_mac: RTL and testbench
=========================

PE_MAC -- requirements
Module: pe_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand and result width (matches the register-file data path).
REQ-002 SHALL have parameter ACC_W, default 40, accumulator width.
REQ-003 SHALL have parameter LEN_W, default 8, term-count width.
REQ-004 SHALL use one clock and a synchronous, active-high reset, ports named clk and reset.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin a dot product.
REQ-008 SHALL have port k_len, input, LEN_W, number of terms, sampled with start.
REQ-009 SHALL have port in_valid, input, 1, operand pair present.
REQ-010 SHALL have port in_ready, output, 1, operand pair accepted when both in_valid and in_ready are high.
REQ-011 SHALL have port a, input, DATA_W, signed operand A.
REQ-012 SHALL have port b, input, DATA_W, signed operand B.
REQ-013 SHALL have port out_we, output, 1, one-cycle write strobe to the downstream reg_file.
REQ-014 SHALL have port out_data, output, DATA_W, result, connected to reg_file data_in.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement the states IDLE, ACCUM, DRAIN and WRITE.
REQ-017 SHALL, in IDLE with start=1, latch k_len, clear the accumulator and term counter, and go to ACCUM; if k_len=0, go straight to WRITE instead.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL drive in_ready=1 only in ACCUM while accepted terms < k_len.
REQ-020 SHALL, on each accepted beat, register the signed product a*b (2*DATA_W bits) and increment the term counter.
REQ-021 SHALL add the registered product, sign-extended to ACC_W, to the accumulator on the edge after the beat is accepted.
REQ-022 SHALL leave the accumulator unchanged in any cycle that has no valid product; gaps in in_valid are legal at any point.
REQ-023 SHALL move from ACCUM to DRAIN on the edge that accepts the final beat, and from DRAIN to WRITE once the last product has been accumulated.
REQ-024 SHALL register out_we high for exactly one cycle, starting on edge N+2 when the last beat is accepted on edge N.
REQ-025 SHALL, for k_len=0, register out_we high with out_data=0 starting on the second edge after start.
REQ-026 SHALL hold out_data stable until the next WRITE, and SHALL return to IDLE after WRITE.
REQ-027 SHALL wrap the accumulator modulo 2^ACC_W on overflow.

Reset
REQ-028 SHALL, with reset=1 at a rising edge, force state IDLE and set out_we=0, out_data=0, in_ready=0, busy=0, accumulator=0, counter=0 and the product-valid flag to 0.
REQ-029 SHALL discard any partial result when reset arrives mid-operation, with no out_we pulse from that operation.
REQ-030 SHALL give reset priority over start and over in_valid in the same cycle.

Configuration
REQ-031 SHALL, with PE_MAC_SAT_EN defined, set out_data to the accumulator clamped to the range -2^(DATA_W-1) to 2^(DATA_W-1)-1.
REQ-032 SHALL, without PE_MAC_SAT_EN, set out_data to accumulator[DATA_W-1:0] (truncation).

Structure
REQ-033 SHALL take DATA_W/ACC_W/LEN_W default constants and the state enum typedef from shared package pe_pkg.
REQ-034 SHALL place the registered signed multiplier, with its valid flag, in sub-module pe_mult.

Verification
REQ-035 SHALL cover: k_len=3, a={2,3,4}, b={5,6,7}, continuous valid -> one out_we pulse 2 cycles after the last beat, out_data=56.
REQ-036 SHALL cover: k_len=2, a={-3,4}, b={5,-2} -> out_data=16'hFFE9 (-23).
REQ-037 SHALL cover: k_len=2, a=b=200 -> out_data=14464 (16'h3880) without the macro, 32767 with PE_MAC_SAT_EN.
REQ-038 SHALL cover: k_len=0 -> out_we pulse with out_data=0, with in_ready never asserted.
REQ-039 SHALL cover: k_len=3 with in_valid gaps of 0, 2 and 1 cycles, plus a start pulse while busy -> result 56, the second start ignored, exactly one out_we.
REQ-040 SHALL cover: reset asserted after 1 of 3 beats -> no out_we, all outputs 0, and a following k_len=1 run with a=7, b=3 produces out_data=21.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared width defaults and state encoding for the MAC processing element
package pe_pkg;
  localparam int PE_DATA_W = 16;
  localparam int PE_ACC_W  = 40;
  localparam int PE_LEN_W  = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, WRITE} state_e;
endpackage

// File: rtl/pe_mult.sv
// pe_mult: registered signed multiplier with a one-cycle product-valid flag
module pe_mult #(
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vld_i,
  input  logic signed [DATA_W-1:0]   a_i,
  input  logic signed [DATA_W-1:0]   b_i,
  output logic signed [2*DATA_W-1:0] p_o,
  output logic                       vld_o
);
  logic signed [2*DATA_W-1:0] p_q;
  logic vld_q;
  // capture the product of each accepted beat; the flag marks it for exactly one cycle
  always_ff @(posedge clk)
    if (reset) begin
      p_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) p_q <= a_i * b_i;
    end
  assign p_o   = p_q;
  assign vld_o = vld_q;
endmodule

// File: rtl/pe_mac.sv
// pe_mac: dot-product MAC feeding a reg_file write port; PE_MAC_SAT_EN selects saturating output
module pe_mac import pe_pkg::*; #(
  parameter int DATA_W = PE_DATA_W,
  parameter int ACC_W  = PE_ACC_W,
  parameter int LEN_W  = PE_LEN_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         k_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     out_we,
  output logic [DATA_W-1:0]        out_data,
  output logic                     busy
);
  state_e state_q, state_d;
  logic [LEN_W-1:0] k_q, cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod;
  logic prod_vld, go, beat, last, we_q;
  logic [DATA_W-1:0] res, data_q;
  assign go       = state_q == IDLE && start;
  assign in_ready = state_q == ACCUM && cnt_q < k_q;
  assign beat     = in_valid && in_ready;
  assign last     = cnt_q + LEN_W'(1) == k_q;
  assign busy     = state_q != IDLE;
  assign out_we   = we_q;
  assign out_data = data_q;
  pe_mult #(.DATA_W(DATA_W)) u_mult (
    .clk   (clk),
    .reset (reset),
    .vld_i (beat),
    .a_i   (a),
    .b_i   (b),
    .p_o   (prod),
    .vld_o (prod_vld)
  );
`ifdef PE_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'({(DATA_W-1){1'b1}});
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;
  assign res = acc_q > MAX_V ? MAX_V[DATA_W-1:0] : acc_q < MIN_V ? MIN_V[DATA_W-1:0] : acc_q[DATA_W-1:0];
`else
  assign res = acc_q[DATA_W-1:0];
`endif
  // sequencing: a zero-length request skips straight to the write cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? (k_len == '0 ? WRITE : ACCUM) : IDLE;
      ACCUM:   state_d = beat && last ? DRAIN : ACCUM;
      DRAIN:   state_d = WRITE;
      default: state_d = IDLE;
    endcase
  end
  // term count and accumulator; the accumulator trails acceptance by one cycle via the multiplier register
  always_comb begin
    cnt_d = go ? '0 : beat ? cnt_q + LEN_W'(1) : cnt_q;
    acc_d = go ? '0 : prod_vld ? acc_q + ACC_W'(prod) : acc_q;
  end
  // state registers; the result is captured and strobed one cycle after WRITE is entered
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      we_q    <= state_q == WRITE;
      if (go) k_q <= k_len;
      if (state_q == WRITE) data_q <= res;
    end
endmodule

// File: tb/tb_pe_mac.sv
// tb_pe_mac: table-driven scoreboard bench for pe_mac
module tb_pe_mac;
  logic clk = 1'b0, reset, start, in_valid, in_ready, out_we, busy;
  logic [7:0] k_len;
  logic signed [15:0] a, b;
  logic [15:0] out_data;
  int total = 0, bad = 0, edges = 0, pulses = 0, rdy_cnt = 0;
  logic [15:0] exp_q[$];
  int edge_q[$];

  typedef struct packed {
    logic [7:0] k;
    logic [0:3][15:0] a;
    logic [0:3][15:0] b;
    logic [0:3][3:0] g;
    logic poke;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[9];

`ifdef PE_MAC_SAT_EN
  localparam logic [15:0] E_BIG = 16'h7FFF, E_HUGE = 16'h7FFF, E_NEG = 16'h8000;
`else
  localparam logic [15:0] E_BIG = 16'h3880, E_HUGE = 16'h0000, E_NEG = 16'hC780;
`endif

  pe_mac dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .out_we(out_we), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  function automatic void chk(string n, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
    edges++;
    if (in_ready) rdy_cnt++;
    if (out_we) begin
      pulses++;
      if (exp_q.size() == 0) chk("unexpected_we", out_we, 0);
      else begin
        chk("data", out_data, exp_q.pop_front());
        chk("latency", edges, edge_q.pop_front());
      end
    end
  endtask

  task automatic run_op(input vec_t v);
    int e, p0, r0;
    p0 = pulses;
    r0 = rdy_cnt;
    start = 1'b1;
    k_len = v.k;
    step;
    start = 1'b0;
    e = edges;
    for (int i = 0; i < int'(v.k); i++) begin
      for (int j = 0; j < int'(v.g[i]); j++) begin
        if (v.poke && i == 1) begin
          start = 1'b1;
          k_len = 8'd5;
        end
        step;
        start = 1'b0;
      end
      in_valid = 1'b1;
      a = v.a[i];
      b = v.b[i];
      for (int t = 0; !in_ready && t < 20; t++) step;
      step;
      e = edges;
      in_valid = 1'b0;
    end
    exp_q.push_back(v.exp);
    edge_q.push_back(e + (v.k == 0 ? 1 : 2));
    for (int t = 0; pulses == p0 && t < 20; t++) step;
    repeat (4) step;
    chk("we_count", pulses - p0, 1);
    chk("drained", exp_q.size(), 0);
    chk("hold", out_data, v.exp);
    chk("idle", busy, 0);
    if (v.k == 0) chk("no_ready", rdy_cnt - r0, 0);
    exp_q.delete();
    edge_q.delete();
  endtask

  initial begin
    vecs[0] = '{k:8'd3, a:{16'd2, 16'd3, 16'd4, 16'd0}, b:{16'd5, 16'd6, 16'd7, 16'd0},
                g:'0, poke:1'b0, exp:16'd56};
    vecs[1] = '{k:8'd2, a:{16'hFFFD, 16'd4, 16'd0, 16'd0}, b:{16'd5, 16'hFFFE, 16'd0, 16'd0},
                g:'0, poke:1'b0, exp:16'hFFE9};
    vecs[2] = '{k:8'd2, a:{16'd200, 16'd200, 16'd0, 16'd0}, b:{16'd200, 16'd200, 16'd0, 16'd0},
                g:'0, poke:1'b0, exp:E_BIG};
    vecs[3] = '{k:8'd0, a:'0, b:'0, g:'0, poke:1'b0, exp:16'd0};
    vecs[4] = '{k:8'd3, a:{16'd2, 16'd3, 16'd4, 16'd0}, b:{16'd5, 16'd6, 16'd7, 16'd0},
                g:{4'd0, 4'd2, 4'd1, 4'd0}, poke:1'b1, exp:16'd56};
    vecs[5] = '{k:8'd4, a:{16'h8000, 16'h8000, 16'h8000, 16'h8000},
                b:{16'h8000, 16'h8000, 16'h8000, 16'h8000}, g:'0, poke:1'b0, exp:E_HUGE};
    vecs[6] = '{k:8'd1, a:{16'h8000, 16'd0, 16'd0, 16'd0}, b:{16'd1, 16'd0, 16'd0, 16'd0},
                g:'0, poke:1'b0, exp:16'h8000};
    vecs[7] = '{k:8'd2, a:{16'hFF38, 16'hFF38, 16'd0, 16'd0}, b:{16'd200, 16'd200, 16'd0, 16'd0},
                g:{4'd3, 4'd0, 4'd0, 4'd0}, poke:1'b0, exp:E_NEG};
    vecs[8] = '{k:8'd1, a:{16'd7, 16'd0, 16'd0, 16'd0}, b:{16'd3, 16'd0, 16'd0, 16'd0},
                g:'0, poke:1'b0, exp:16'd21};
    reset = 1'b1;
    start = 1'b1;
    in_valid = 1'b1;
    k_len = 8'd3;
    a = 16'd1;
    b = 16'd1;
    repeat (3) step;
    chk("rst_we", out_we, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    step;
    for (int i = 0; i < 8; i++) run_op(vecs[i]);
    begin
      int p0;
      p0 = pulses;
      start = 1'b1;
      k_len = 8'd3;
      step;
      start = 1'b0;
      in_valid = 1'b1;
      a = 16'd2;
      b = 16'd5;
      step;
      reset = 1'b1;
      start = 1'b1;
      a = 16'd3;
      b = 16'd6;
      step;
      chk("mid_rst_we", out_we, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_busy", busy, 0);
      reset = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      repeat (6) step;
      chk("mid_rst_no_we", pulses - p0, 0);
    end
    run_op(vecs[8]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
